ptp_ts_queue_axil: RTL
======================

// Module: ptp_ts_queue_axil
// PURPOSE
//  Parametrised PTP timestamp capture queue with a fully handshaked AXI4-Lite register port.
//  Holds N_CH independent FIFOs of 128-bit event records, filtered per channel by PTP messageType.
//  Generates a maskable level interrupt when queues are non-empty.
//  Sits between the per-port TSU capture logic and the CPU; capture strobes are already in S_AXI_REG_ACLK.
// PARAMETERS
//  N_CH        4   channel count, 1..8
//  DEPTH       8   entries per channel FIFO, power of 2, 2..64
//  ADDR_WIDTH  12  AXI address width; only [11:2] are decoded
// PORTS
//  S_AXI_REG_ACLK     in   1             register/queue clock
//  S_AXI_REG_ARESETN  in   1             async active-low reset
//  S_AXI_REG_AW*/W*/B*/AR*/R*  AXI4-Lite slave, 32-bit data, WSTRB ignored, PROT ignored
//  ts_valid           in   N_CH          1-cycle capture strobe per channel
//  ts_time            in   N_CH*80       {sec[47:0], ns[31:0]} per channel
//  ts_msgid           in   N_CH*4        PTP messageType per channel
//  ts_seqid           in   N_CH*16       PTP sequenceId per channel
//  INTR_OUT           out  1             level interrupt
// BEHAVIOUR
//  Reset: S_AXI_REG_ARESETN is async active-low on clock S_AXI_REG_ACLK; all FIFOs are emptied.
//   Outputs reset to: AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=0, INTR_OUT=0.
//   IRQ_EN resets to 0, OVF resets to 0. Every channel MASK resets to 16'h000D (Sync, Pdelay_Req, Pdelay_Resp).
//  AXI write:
//   - AW and W are accepted independently; each READY drops after its beat until the write commits.
//   - The write commits in the cycle after both are held. BVALID then rises and stays high until BREADY.
//   - AWREADY and WREADY return to 1 in the cycle after the B handshake. Only one write is outstanding.
//  AXI read:
//   - AR handshake: ARREADY drops, RDATA is registered and RVALID rises on the next cycle.
//   - RVALID and RDATA hold until RREADY. ARREADY returns the cycle after the R handshake.
//   - Unmapped addresses: reads return 0 with OKAY; writes are ignored.
//  Register map:
//   - 0x000 IRQ_EN  RW [N_CH-1:0]
//   - 0x004 IRQ_STAT RO: bit c = !empty[c] & IRQ_EN[c]
//   - 0x008 OVF RW1C sticky per channel
//   - Channel c base = 0x100 + c*0x20:
//     - +0x00 STAT RO {16'h0, count[7:0], 6'h0, full, empty}
//     - +0x04 MASK RW [15:0]
//     - +0x08 DATA0 = head ns[31:0]
//     - +0x0C DATA1 = head sec[31:0]
//     - +0x10 DATA2 = {seqid, sec[47:32]}
//     - +0x14 DATA3 = {28'h0, msgid}
//     - +0x18 POP (WO, any write data)
//   - DATA reads are non-destructive. When the channel is empty they return 0.
//  Push: on ts_valid[c] & MASK[c][ts_msgid[c]] the record is written at the tail in the same cycle.
//   - count is visible in STAT on the next cycle. Masked messageTypes are dropped silently, with no OVF.
//  Full: a push when count==DEPTH and no pop that cycle is dropped and sets OVF[c]. Queue contents are unchanged.
//  Simultaneous push and pop on one channel: both take effect and count is unchanged, including when full.
//   When full this is not an overflow.
//  POP on an empty channel: no effect, no error.
//  Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; count = wr_ptr - rd_ptr.
//  OVF: a W1C clear and a new overflow in the same cycle leave the bit set.
//  INTR_OUT is registered: INTR_OUT <= |IRQ_STAT. It lags state by 1 cycle.
//  Reset mid-transaction aborts it. No B or R beat is issued for an aborted transaction.
// TESTING
//  1. Reset, read 0x104 -> 0x0000_000D. Read 0x100 -> 0x0000_0001 (empty).
//  2. ch1 push msgid=0, seq=0x1234, time={48'h5,32'd999}. Read 0x128 -> 999, 0x12C -> 5, 0x130 -> 0x1234_0000, 0x134 -> 0. Write 0x138, then read 0x120 -> empty.
//  3. ch0 push msgid=0xB (masked) -> count stays 0. Write MASK=0xFFFF, repeat -> count=1.
//  4. Push DEPTH+1 on ch2 -> count=8, full=1, OVF=0x4. Write 0x008=0x4 -> OVF=0. Head is the first record.
//  5. ch3 full + simultaneous push & POP for 20 cycles -> count stays 8, OVF stays 0, FIFO order preserved across wrap.
//  6. IRQ_EN=0x1, push ch0 -> INTR_OUT=1 one cycle later. Pop -> INTR_OUT=0. AW before W by 3 cycles and BREADY held low 5 cycles -> exactly one B beat.

Source files
------------

// File: rtl/ptp_ts_queue_axil.sv
// ptp_ts_queue_axil: per-channel PTP timestamp FIFOs exposed through an AXI4-Lite register port.
// Ports:
//   S_AXI_REG_ACLK/ARESETN    clock, async active-low reset
//   S_AXI_REG_AW/W/B/AR/R*    AXI4-Lite slave, 32-bit data (WSTRB and PROT not used)
//   ts_valid/time/msgid/seqid per-channel capture strobe and record fields from the TSUs
//   INTR_OUT                  registered level interrupt: any enabled channel non-empty
module ptp_ts_queue_axil #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  S_AXI_REG_ACLK,
    input  logic                  S_AXI_REG_ARESETN,
    input  logic [ADDR_WIDTH-1:0] S_AXI_REG_AWADDR,
    input  logic [2:0]            S_AXI_REG_AWPROT,
    input  logic                  S_AXI_REG_AWVALID,
    output logic                  S_AXI_REG_AWREADY,
    input  logic [31:0]           S_AXI_REG_WDATA,
    input  logic [3:0]            S_AXI_REG_WSTRB,
    input  logic                  S_AXI_REG_WVALID,
    output logic                  S_AXI_REG_WREADY,
    output logic [1:0]            S_AXI_REG_BRESP,
    output logic                  S_AXI_REG_BVALID,
    input  logic                  S_AXI_REG_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_REG_ARADDR,
    input  logic [2:0]            S_AXI_REG_ARPROT,
    input  logic                  S_AXI_REG_ARVALID,
    output logic                  S_AXI_REG_ARREADY,
    output logic [31:0]           S_AXI_REG_RDATA,
    output logic [1:0]            S_AXI_REG_RRESP,
    output logic                  S_AXI_REG_RVALID,
    input  logic                  S_AXI_REG_RREADY,
    input  logic [N_CH-1:0]       ts_valid,
    input  logic [N_CH*80-1:0]    ts_time,
    input  logic [N_CH*4-1:0]     ts_msgid,
    input  logic [N_CH*16-1:0]    ts_seqid,
    output logic                  INTR_OUT
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned REC_W = 128;

    // Word addresses (byte address [11:2])
    localparam logic [9:0] A_IRQ_EN   = 10'h000;
    localparam logic [9:0] A_IRQ_STAT = 10'h001;
    localparam logic [9:0] A_OVF      = 10'h002;
    localparam logic [9:0] A_CH_BASE  = 10'h040;
    localparam logic [2:0] O_STAT  = 3'd0;
    localparam logic [2:0] O_MASK  = 3'd1;
    localparam logic [2:0] O_DATA0 = 3'd2;
    localparam logic [2:0] O_DATA1 = 3'd3;
    localparam logic [2:0] O_DATA2 = 3'd4;
    localparam logic [2:0] O_DATA3 = 3'd5;
    localparam logic [2:0] O_POP   = 3'd6;

    function automatic logic [9:0] ch_word(input int unsigned c, input logic [2:0] off);
        return A_CH_BASE + 10'(c * 8) + 10'(off);
    endfunction

    logic clk, rst_n;
    assign clk   = S_AXI_REG_ACLK;
    assign rst_n = S_AXI_REG_ARESETN;

    logic [9:0]  wr_word;
    logic [31:0] wr_data;
    logic        commit_c;
    logic [9:0]  rd_word_c;
    logic [31:0] rd_mux_c;

    logic [N_CH-1:0][PTR_W-1:0] wr_ptr, rd_ptr, cnt_c;
    logic [N_CH-1:0][15:0]      mask;
    logic [N_CH-1:0][REC_W-1:0] rec_c, head_c;
    logic [N_CH-1:0]            irq_en, ovf, ovf_clr_c, irq_stat_c;
    logic [N_CH-1:0]            empty_c, full_c, push_req_c, push_c, pop_c, ovf_set_c;
    logic [REC_W-1:0]           mem [N_CH][DEPTH];

    logic unused_c;
    assign unused_c = ^{S_AXI_REG_AWPROT, S_AXI_REG_ARPROT, S_AXI_REG_WSTRB,
                        S_AXI_REG_AWADDR, S_AXI_REG_ARADDR, wr_data};

    assign S_AXI_REG_BRESP = 2'b00;
    assign S_AXI_REG_RRESP = 2'b00;

    // Both halves of the write are captured (READYs low) and B not yet issued
    assign commit_c  = !S_AXI_REG_AWREADY && !S_AXI_REG_WREADY && !S_AXI_REG_BVALID;
    assign rd_word_c = S_AXI_REG_ARADDR[11:2];

    // Per-channel FIFO status and push/pop arbitration
    always_comb begin
        cnt_c      = '0;
        empty_c    = '0;
        full_c     = '0;
        push_req_c = '0;
        pop_c      = '0;
        push_c     = '0;
        ovf_set_c  = '0;
        rec_c      = '0;
        head_c     = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            cnt_c[c]      = wr_ptr[c] - rd_ptr[c];
            empty_c[c]    = (cnt_c[c] == '0);
            full_c[c]     = (cnt_c[c] == PTR_W'(DEPTH));
            push_req_c[c] = ts_valid[c] & mask[c][ts_msgid[c*4 +: 4]];
            pop_c[c]      = commit_c & (wr_word == ch_word(c, O_POP)) & ~empty_c[c];
            // A pop in the same cycle frees the slot, so a full queue still accepts
            push_c[c]     = push_req_c[c] & (~full_c[c] | pop_c[c]);
            ovf_set_c[c]  = push_req_c[c] & full_c[c] & ~pop_c[c];
            rec_c[c]      = {28'h0, ts_msgid[c*4 +: 4], ts_seqid[c*16 +: 16], ts_time[c*80 +: 80]};
            head_c[c]     = empty_c[c] ? '0 : mem[c][rd_ptr[c][IDX_W-1:0]];
        end
        irq_stat_c = ~empty_c & irq_en;
        ovf_clr_c  = (commit_c && wr_word == A_OVF) ? wr_data[N_CH-1:0] : '0;
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (push_c[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                if (pop_c[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (push_c[c]) mem[c][wr_ptr[c][IDX_W-1:0]] <= rec_c[c];
        end
    end

    // Control registers, sticky overflow and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en   <= '0;
            ovf      <= '0;
            mask     <= {N_CH{16'h000D}};
            INTR_OUT <= 1'b0;
        end else begin
            if (commit_c && wr_word == A_IRQ_EN) irq_en <= wr_data[N_CH-1:0];
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (commit_c && wr_word == ch_word(c, O_MASK)) mask[c] <= wr_data[15:0];
            end
            // A new overflow wins over a concurrent W1C
            ovf      <= (ovf & ~ovf_clr_c) | ovf_set_c;
            INTR_OUT <= |irq_stat_c;
        end
    end

    // Read data mux
    always_comb begin
        rd_mux_c = '0;
        case (rd_word_c)
            A_IRQ_EN:   rd_mux_c = 32'(irq_en);
            A_IRQ_STAT: rd_mux_c = 32'(irq_stat_c);
            A_OVF:      rd_mux_c = 32'(ovf);
            default:    ;
        endcase
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (rd_word_c == ch_word(c, O_STAT))
                rd_mux_c = {16'h0, 8'(cnt_c[c]), 6'h0, full_c[c], empty_c[c]};
            if (rd_word_c == ch_word(c, O_MASK))  rd_mux_c = 32'(mask[c]);
            if (rd_word_c == ch_word(c, O_DATA0)) rd_mux_c = head_c[c][31:0];
            if (rd_word_c == ch_word(c, O_DATA1)) rd_mux_c = head_c[c][63:32];
            if (rd_word_c == ch_word(c, O_DATA2)) rd_mux_c = head_c[c][95:64];
            if (rd_word_c == ch_word(c, O_DATA3)) rd_mux_c = head_c[c][127:96];
        end
    end

    // AXI4-Lite handshakes: single outstanding write and read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_AXI_REG_AWREADY <= 1'b1;
            S_AXI_REG_WREADY  <= 1'b1;
            S_AXI_REG_BVALID  <= 1'b0;
            S_AXI_REG_ARREADY <= 1'b1;
            S_AXI_REG_RVALID  <= 1'b0;
            S_AXI_REG_RDATA   <= '0;
            wr_word           <= '0;
            wr_data           <= '0;
        end else begin
            if (S_AXI_REG_AWVALID && S_AXI_REG_AWREADY) begin
                S_AXI_REG_AWREADY <= 1'b0;
                wr_word           <= S_AXI_REG_AWADDR[11:2];
            end
            if (S_AXI_REG_WVALID && S_AXI_REG_WREADY) begin
                S_AXI_REG_WREADY <= 1'b0;
                wr_data          <= S_AXI_REG_WDATA;
            end
            if (commit_c) S_AXI_REG_BVALID <= 1'b1;
            if (S_AXI_REG_BVALID && S_AXI_REG_BREADY) begin
                S_AXI_REG_BVALID  <= 1'b0;
                S_AXI_REG_AWREADY <= 1'b1;
                S_AXI_REG_WREADY  <= 1'b1;
            end
            if (S_AXI_REG_ARVALID && S_AXI_REG_ARREADY) begin
                S_AXI_REG_ARREADY <= 1'b0;
                S_AXI_REG_RVALID  <= 1'b1;
                S_AXI_REG_RDATA   <= rd_mux_c;
            end
            if (S_AXI_REG_RVALID && S_AXI_REG_RREADY) begin
                S_AXI_REG_RVALID  <= 1'b0;
                S_AXI_REG_ARREADY <= 1'b1;
            end
        end
    end
endmodule
